x25519_reduce_pipe: RTL and testbench

Pipelined, parametrised reduction unit for GF(2^255-19), and the next generation of the X25519 squeeze stage. Accepts one operand per cycle of up to IN_WIDTH bits and folds all bits at and above 255 back in with multiplier 19, twice, so the result is always < 2^255. Optionally performs a final canonical "freeze" so the result is < p. Sits between the X25519 multiplier/adder datapath and the ladder control, with valid/ready flow control and a tag passed through for each operation.

---
 rtl/x25519_reduce_pipe_pkg.sv | 19 +
 rtl/x25519_reduce_pipe_if.sv | 28 ++
 rtl/x25519_reduce_pipe_fold_stage.sv | 49 ++++
 rtl/x25519_reduce_pipe.sv | 68 ++++++
 tb/tb_x25519_reduce_pipe.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/x25519_reduce_pipe_pkg.sv
// Shared constants and types for the GF(2^255-19) reduction pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package x25519_pkg;

   localparam int FE_W     = 256;
   localparam int FOLD_BIT = 255;
   localparam int unsigned FOLD_MUL = 19;

   typedef logic [FE_W-1:0] fe_t;

   // p = 2^255 - 19 = 0x7fff...ffed
   localparam fe_t P = {1'b0, {247{1'b1}}, 8'hed};

   function automatic logic [1:0] popcount3(input logic a, input logic b, input logic c);
      return {1'b0, a} + {1'b0, b} + {1'b0, c};
   endfunction

endpackage

// File: rtl/x25519_reduce_pipe_if.sv
// Operand/result bus of the reduction pipeline, valid/ready on both sides.
// Latency: n/a (wires only).
// Backpressure: out_ready is fed back combinationally to in_ready by the slave.
interface x25519_reduce_pipe_if #(
   parameter int IN_WIDTH  = 264,
   parameter int TAG_WIDTH = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [IN_WIDTH-1:0]  in_data;
   logic                 in_freeze;
   logic [TAG_WIDTH-1:0] in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [255:0]         out_data;
   logic [TAG_WIDTH-1:0] out_tag;
   logic [1:0]           in_flight;

   modport master (
      output in_valid, in_data, in_freeze, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, in_flight
   );

   modport slave (
      input  in_valid, in_data, in_freeze, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, in_flight
   );
endinterface

// File: rtl/x25519_reduce_pipe_fold_stage.sv
// One registered fold: o_dat = i_dat[254:0] + 19*i_dat[IN_W-1:255], tag/freeze carried along.
// Latency: 1 cycle.
// Backpressure: holds all state while i_stall is high; bubbles advance otherwise.
module x25519_fold_stage
   import x25519_pkg::*;
#(
   parameter int IN_W  = 264,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_stall,
   input  logic             i_vld,
   input  logic [IN_W-1:0]  i_dat,
   input  logic             i_frz,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_vld,
   output fe_t              o_dat,
   output logic             o_frz,
   output logic [TAG_W-1:0] o_tag
);
   localparam int HI_W = IN_W - FOLD_BIT;

   logic [HI_W-1:0] w_hi;
   fe_t             w_lo;
   fe_t             w_sum;

   assign w_hi  = i_dat[IN_W-1:FOLD_BIT];
   assign w_lo  = {1'b0, i_dat[FOLD_BIT-1:0]};
   // Cannot overflow 256 bits for IN_W <= 300: 19*2^45 is far below 2^255.
   assign w_sum = w_lo + fe_t'(w_hi) * fe_t'(FOLD_MUL);

   // Stage register: valid always advances unless stalled, payload only loads with a real operand.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_vld <= 1'b0;
         o_dat <= '0;
         o_frz <= 1'b0;
         o_tag <= '0;
      end else if (!i_stall) begin
         o_vld <= i_vld;
         if (i_vld) begin
            o_dat <= w_sum;
            o_frz <= i_frz;
            o_tag <= i_tag;
         end
      end
   end
endmodule

// File: rtl/x25519_reduce_pipe.sv
// GF(2^255-19) reduction: fold A, fold B, optional canonical freeze (X25519_REDUCE_FREEZE_EN).
// Latency: 3 register stages; operand presented in cycle k appears as a result in cycle k+3.
// Backpressure: global stall (out_valid && !out_ready) freezes every stage; in_ready = !stall.
module x25519_reduce_pipe
   import x25519_pkg::*;
#(
   parameter int IN_WIDTH  = 264,
   parameter int TAG_WIDTH = 4
) (
   input  logic clk,
   input  logic rst,
   x25519_reduce_pipe_if.slave bus
);
   logic                 w_stall;
   logic                 w_vld1, w_frz1, w_vld2, w_frz2;
   fe_t                  w_dat1, w_dat2, w_dat3;
   logic [TAG_WIDTH-1:0] w_tag1, w_tag2;
   logic                 r_vld3;
   fe_t                  r_dat3;
   logic [TAG_WIDTH-1:0] r_tag3;

   assign w_stall      = r_vld3 && !bus.out_ready;
   assign bus.in_ready = !w_stall;

   x25519_fold_stage #(.IN_W(IN_WIDTH), .TAG_W(TAG_WIDTH)) u_fold_a (
      .clk(clk), .rst(rst), .i_stall(w_stall),
      .i_vld(bus.in_valid), .i_dat(bus.in_data), .i_frz(bus.in_freeze), .i_tag(bus.in_tag),
      .o_vld(w_vld1), .o_dat(w_dat1), .o_frz(w_frz1), .o_tag(w_tag1)
   );

   // Second fold absorbs the single possible carry out of bit 255 from fold A.
   x25519_fold_stage #(.IN_W(FE_W), .TAG_W(TAG_WIDTH)) u_fold_b (
      .clk(clk), .rst(rst), .i_stall(w_stall),
      .i_vld(w_vld1), .i_dat(w_dat1), .i_frz(w_frz1), .i_tag(w_tag1),
      .o_vld(w_vld2), .o_dat(w_dat2), .o_frz(w_frz2), .o_tag(w_tag2)
   );

`ifdef X25519_REDUCE_FREEZE_EN
   logic [254:0] w_plus19;
   // s2 < 2^255 = p + 19, so a single conditional subtract of p (add 19, drop bit 255) suffices.
   assign w_plus19 = w_dat2[254:0] + 255'(FOLD_MUL);
   assign w_dat3   = (w_frz2 && (w_dat2 >= P)) ? {1'b0, w_plus19} : w_dat2;
`else
   logic w_unused_frz;
   assign w_unused_frz = w_frz2;
   assign w_dat3       = w_dat2;
`endif

   // Output stage register; held while the consumer is not taking the result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld3 <= 1'b0;
         r_dat3 <= '0;
         r_tag3 <= '0;
      end else if (!w_stall) begin
         r_vld3 <= w_vld2;
         if (w_vld2) begin
            r_dat3 <= w_dat3;
            r_tag3 <= w_tag2;
         end
      end
   end

   assign bus.out_valid = r_vld3;
   assign bus.out_data  = r_dat3;
   assign bus.out_tag   = r_tag3;
   assign bus.in_flight = popcount3(w_vld1, w_vld2, r_vld3);
endmodule

// File: tb/tb_x25519_reduce_pipe.sv
// Directed bench for x25519_reduce_pipe: reset, squeeze, double fold, freeze, streaming, stall, reset mid-flight.
// Latency: checks result three cycles after the acceptance cycle.
// Backpressure: drops out_ready for four cycles during a stream.
module tb_x25519_reduce_pipe;
   localparam int IW = 264;
   localparam int TW = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   x25519_reduce_pipe_if #(.IN_WIDTH(IW), .TAG_WIDTH(TW)) bus ();

   x25519_reduce_pipe #(.IN_WIDTH(IW), .TAG_WIDTH(TW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One isolated operand: result must appear exactly in the third sample after acceptance.
   task automatic single(input string tag, input logic [IW-1:0] d, input logic f,
                         input logic [TW-1:0] t, input logic [255:0] exp);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.in_freeze = f;
      bus.in_tag    = t;
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_freeze = 1'b0;
      check({tag, "_vld_c1"}, 256'(bus.out_valid), 256'(0));
      @(posedge clk); #1;
      check({tag, "_vld_c2"}, 256'(bus.out_valid), 256'(0));
      @(posedge clk); #1;
      check({tag, "_vld_c3"}, 256'(bus.out_valid), 256'(1));
      check({tag, "_data"}, bus.out_data, exp);
      check({tag, "_tag"}, 256'(bus.out_tag), 256'(t));
      @(posedge clk); #1;
      check({tag, "_drain"}, 256'(bus.out_valid), 256'(0));
   endtask

   logic [255:0] p_val;
   logic [255:0] ones255;
   logic [255:0] rx_dat[$];
   logic [TW-1:0] rx_tag[$];
   logic [255:0] held_dat;
   logic [TW-1:0] held_tag;

   initial begin
      int first, last, peak, idx, stale;
      logic acc;
      p_val   = {1'b0, {247{1'b1}}, 8'hed};
      ones255 = {1'b0, {255{1'b1}}};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_freeze = 1'b0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
      #1;
      check("rst_in_ready", 256'(bus.in_ready), 256'(1));
      check("rst_out_valid", 256'(bus.out_valid), 256'(0));
      check("rst_out_data", bus.out_data, 256'(0));
      check("rst_out_tag", 256'(bus.out_tag), 256'(0));
      check("rst_in_flight", 256'(bus.in_flight), 256'(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("post_rst_in_ready", 256'(bus.in_ready), 256'(1));
      check("post_rst_in_flight", 256'(bus.in_flight), 256'(0));

      // Squeeze with one carried bit, then a value already below 2^255.
      single("squeeze", {8'h0, 256'hdc21740e549bcdab5e580525a3310d66c9332e76e71b547ce3f2ba294a516967},
             1'b0, 4'h3, 256'h5c21740e549bcdab5e580525a3310d66c9332e76e71b547ce3f2ba294a51697a);
      single("passthru", {8'h0, 256'h7dba22bb0123456789abcdef0123456789abcdef0123456789abcdef3ae9f705},
             1'b0, 4'h7, 256'h7dba22bb0123456789abcdef0123456789abcdef0123456789abcdef3ae9f705);

      // All ones: fold A carries out, fold B adds the final 19 -> 0x25ff.
      single("ones_f0", {IW{1'b1}}, 1'b0, 4'h9, 256'h25ff);
      single("ones_f1", {IW{1'b1}}, 1'b1, 4'ha, 256'h25ff);

`ifdef X25519_REDUCE_FREEZE_EN
      single("frz_p", {8'h0, p_val}, 1'b1, 4'h1, 256'h0);
      single("frz_pm1", {8'h0, p_val - 256'd1}, 1'b1, 4'h2, p_val - 256'd1);
      single("frz_2p255m1", {8'h0, ones255}, 1'b1, 4'h4, 256'h12);
      single("nofrz_2p255m1", {8'h0, ones255}, 1'b0, 4'h5, ones255);
`else
      single("nofrz_build_p", {8'h0, p_val}, 1'b1, 4'h1, p_val);
      single("nofrz_build_2p255m1", {8'h0, ones255}, 1'b1, 4'h4, ones255);
`endif

      // Streaming: five back-to-back operands, operand t = 2^255 + t -> t + 19.
      first = -1; last = -1; peak = 0;
      rx_dat.delete(); rx_tag.delete();
      for (int c = 0; c < 9; c++) begin
         if (c < 5) begin
            bus.in_valid = 1'b1;
            bus.in_tag   = TW'(c + 1);
            bus.in_data  = {9'h1, 255'(c + 1)};
         end else begin
            bus.in_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (bus.out_valid) begin
            rx_dat.push_back(bus.out_data);
            rx_tag.push_back(bus.out_tag);
            if (first < 0) first = c;
            last = c;
         end
         if (int'(bus.in_flight) > peak) peak = int'(bus.in_flight);
      end
      check("stream_count", 256'(rx_dat.size()), 256'(5));
      check("stream_consecutive", 256'(last - first), 256'(4));
      check("stream_peak_in_flight", 256'(peak), 256'(3));
      for (int k = 0; k < 5 && k < rx_dat.size(); k++) begin
         check($sformatf("stream_tag%0d", k), 256'(rx_tag[k]), 256'(k + 1));
         check($sformatf("stream_dat%0d", k), rx_dat[k], 256'(k + 1 + 19));
      end

      // Backpressure: six operands t -> 3*2^255 + 7t, result 7t + 57; consumer stalls cycles 4..7.
      idx = 0;
      rx_dat.delete(); rx_tag.delete();
      held_dat = '0; held_tag = '0;
      for (int c = 0; c < 20; c++) begin
         bus.out_ready = !(c >= 4 && c < 8);
         bus.in_valid  = (idx < 6);
         bus.in_tag    = TW'(idx + 1);
         bus.in_data   = {9'h3, 255'(7 * (idx + 1))};
         #2;
         if (c >= 4 && c < 8) begin
            check($sformatf("bp_in_ready_c%0d", c), 256'(bus.in_ready), 256'(0));
            check($sformatf("bp_out_valid_c%0d", c), 256'(bus.out_valid), 256'(1));
            if (c == 4) begin
               held_dat = bus.out_data;
               held_tag = bus.out_tag;
            end else begin
               check($sformatf("bp_hold_dat_c%0d", c), bus.out_data, held_dat);
               check($sformatf("bp_hold_tag_c%0d", c), 256'(bus.out_tag), 256'(held_tag));
            end
         end
         acc = bus.in_valid && bus.in_ready;
         if (bus.out_valid && bus.out_ready) begin
            rx_dat.push_back(bus.out_data);
            rx_tag.push_back(bus.out_tag);
         end
         @(posedge clk); #1;
         if (acc) idx++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("bp_count", 256'(rx_dat.size()), 256'(6));
      for (int k = 0; k < 6 && k < rx_dat.size(); k++) begin
         check($sformatf("bp_tag%0d", k), 256'(rx_tag[k]), 256'(k + 1));
         check($sformatf("bp_dat%0d", k), rx_dat[k], 256'(7 * (k + 1) + 57));
      end

      // Reset with three operands in flight.
      for (int c = 0; c < 3; c++) begin
         bus.in_valid = 1'b1;
         bus.in_tag   = TW'(c + 8);
         bus.in_data  = {9'h1, 255'(c)};
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      check("mid_in_flight", 256'(bus.in_flight), 256'(3));
      #2 rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 256'(bus.out_valid), 256'(0));
      check("mid_rst_in_flight", 256'(bus.in_flight), 256'(0));
      check("mid_rst_in_ready", 256'(bus.in_ready), 256'(1));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      stale = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.out_valid) stale++;
      end
      check("mid_rst_no_stale", 256'(stale), 256'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
